// File: rtl/bnn_conv_pkg.sv
// Shared constants, layer encodings and FSM state codes for the BNN 5x5 convolution core.
package bnn_conv_pkg;

  localparam int K  = 5;
  localparam int DW = 8;
  localparam int OW = 32;
  localparam int W0 = 28;
  localparam int W1 = 12;

  localparam logic LAYER1 = 1'b0;
  localparam logic LAYER2 = 1'b1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;

  // Index of the last row/column for the selected layer's image edge.
  function automatic logic [4:0] edge_last(input logic layer);
    return (layer == LAYER2) ? 5'(W1 - 1) : 5'(W0 - 1);
  endfunction

endpackage

// File: rtl/bnn_conv_core_line_window.sv
// Four line buffers turning a raster pixel stream into registered 5-pixel vertical columns.
module line_window
  import bnn_conv_pkg::*;
(
  input  logic            clk,
  input  logic            rstn,
  input  logic            clr,
  input  logic            en,
  input  logic            layer,
  input  logic [DW-1:0]   din,
  output logic [K*DW-1:0] taps,
  output logic            taps_valid
);

  logic [DW-1:0] lb [K-1][W0];
  logic [4:0]    col;
  logic [4:0]    last;

  assign last = edge_last(layer);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int unsigned k = 0; k < K - 1; k++)
        for (int unsigned x = 0; x < W0; x++)
          lb[k][x] <= '0;
      col        <= '0;
      taps       <= '0;
      taps_valid <= 1'b0;
    end else begin
      taps_valid <= en;
      if (clr) begin
        col <= '0;
      end else if (en) begin
        // lb[0] holds the previous row; each buffer ages its entry down one row.
        taps     <= {lb[3][col], lb[2][col], lb[1][col], lb[0][col], din};
        lb[0][col] <= din;
        lb[1][col] <= lb[0][col];
        lb[2][col] <= lb[1][col];
        lb[3][col] <= lb[2][col];
        col <= (col == last) ? '0 : col + 5'd1;
      end
    end
  end

endmodule

// File: rtl/bnn_conv_core.sv
// Binary-weight 5x5 convolution: kernel shift register, window, adder tree, counters and frame FSM.
module bnn_conv_core
  import bnn_conv_pkg::*;
(
  input  logic          clk,
  input  logic          rstn,
  input  logic          start,
  input  logic          state,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  input  logic          weight_en,
  input  logic          weight,
  output logic [OW-1:0] dout,
  output logic          ovalid,
  output logic          done
);

  localparam int SW = 16;

  logic [0:0]            fsm;
  logic                  layer;
  logic [K*K-1:0]        w;
  logic [4:0]            row;
  logic [4:0]            col;
  logic [4:0]            last;
  logic [K*DW-1:0]       taps;
  logic                  taps_valid;
  logic [K*DW-1:0]       win [K];
  logic                  out_pend;
  logic                  done_pend;
  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  term;
  logic                  arm;
  logic                  en;

  assign arm  = (fsm == IDLE) && start;
  assign en   = (fsm == RUN) && din_valid;
  assign last = edge_last(layer);

  line_window u_line_window (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (arm),
    .en         (en),
    .layer      (layer),
    .din        (din),
    .taps       (taps),
    .taps_valid (taps_valid)
  );

  always_ff @(posedge clk) begin
    if (!rstn) w <= '0;
    else if (weight_en) w <= {w[K*K-2:0], weight};
  end

  // win[0] is the leftmost column; within a column the top row sits in the high byte.
  always_comb begin
    sum  = '0;
    term = '0;
    for (int unsigned i = 0; i < K; i++) begin
      for (int unsigned j = 0; j < K; j++) begin
        term = {{(SW-DW){1'b0}}, win[j][DW*(K-1-i) +: DW]};
        if (w[K*K-1-(K*i+j)]) sum = sum + term;
        else                  sum = sum - term;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fsm       <= IDLE;
      layer     <= LAYER1;
      row       <= '0;
      col       <= '0;
      out_pend  <= 1'b0;
      done_pend <= 1'b0;
      ovalid    <= 1'b0;
      done      <= 1'b0;
      dout      <= '0;
      for (int unsigned k = 0; k < K; k++) win[k] <= '0;
    end else begin
      out_pend  <= 1'b0;
      done_pend <= 1'b0;
      ovalid    <= out_pend;
      done      <= done_pend;
      if (out_pend) dout <= {{(OW-SW){sum[SW-1]}}, sum};
      if (arm) begin
        fsm   <= RUN;
        layer <= state;
        row   <= '0;
        col   <= '0;
      end else if (fsm == RUN) begin
        if (done_pend) fsm <= IDLE;
        if (taps_valid) begin
          for (int unsigned k = 0; k < K - 1; k++) win[k] <= win[k+1];
          win[K-1]  <= taps;
          out_pend  <= (row >= 5'(K-1)) && (col >= 5'(K-1));
          done_pend <= (row == last) && (col == last);
          if (col == last) begin
            col <= '0;
            row <= row + 5'd1;
          end else begin
            col <= col + 5'd1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_bnn_conv_core.sv
// Scoreboard bench for bnn_conv_core: expected sums queued as each completing pixel is driven.
module tb_bnn_conv_core;
  import bnn_conv_pkg::*;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          start = 1'b0;
  logic          state = 1'b0;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic          weight_en = 1'b0;
  logic          weight = 1'b0;
  logic [OW-1:0] dout;
  logic          ovalid;
  logic          done;

  typedef struct {
    logic [OW-1:0] v;
    logic          last;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc = 0;
  int unsigned first_ov = 0;
  int unsigned acc_edge = 0;
  bit          seen_ov = 1'b0;
  bit          ignore = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  bnn_conv_core dut (
    .clk       (clk),
    .rstn      (rstn),
    .start     (start),
    .state     (state),
    .din_valid (din_valid),
    .din       (din),
    .weight_en (weight_en),
    .weight    (weight),
    .dout      (dout),
    .ovalid    (ovalid),
    .done      (done)
  );

  task automatic check_eq(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%h) expected %0d (0x%h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask

  function automatic logic [DW-1:0] pix(input int sc, input int r, input int c);
    case (sc)
      1:       return DW'(1);
      2:       return DW'(255);
      3:       return (r == 10 && c == 10) ? DW'(100) : DW'(0);
      default: return DW'(c);
    endcase
  endfunction

  function automatic logic [OW-1:0] exp_val(input int sc, input int r, input int c);
    int v;
    case (sc)
      1: v = -25;
      2: v = 6375;
      3: v = (r == 10 && c == 10) ? 100 :
             (r >= 6 && r <= 10 && c >= 6 && c <= 10) ? -100 : 0;
      default: v = 25 * c + 50;
    endcase
    return OW'(v);
  endfunction

  // k[24] is kernel position (0,0) and is shifted in first.
  task automatic load_w(input logic [24:0] k);
    for (int i = 24; i >= 0; i--) begin
      weight    = k[i];
      weight_en = 1'b1;
      @(negedge clk);
    end
    weight_en = 1'b0;
  endtask

  task automatic run_frame(input int sc, input logic lay, input int gap, input int npix, input int lat_idx);
    int w;
    int r;
    int c;
    w = lay ? W1 : W0;
    state = lay;
    start = 1'b1;
    @(negedge clk);
    start   = 1'b0;
    seen_ov = 1'b0;
    for (int idx = 0; idx < npix; idx++) begin
      r = idx / w;
      c = idx % w;
      din       = pix(sc, r, c);
      din_valid = 1'b1;
      if (!ignore && r >= 4 && c >= 4)
        sb.push_back('{v: exp_val(sc, r - 4, c - 4), last: (r == w - 1 && c == w - 1)});
      if (idx == lat_idx) acc_edge = cyc + 1;
      @(negedge clk);
      for (int g = 0; g < gap; g++) begin
        din_valid = 1'b0;
        @(negedge clk);
      end
    end
    din_valid = 1'b0;
    din       = '0;
  endtask

  task automatic drain;
    int t;
    t = 0;
    while (sb.size() != 0 && t < 200) begin
      @(negedge clk);
      t++;
    end
    check_eq("drain_left", 32'(sb.size()), 0);
    repeat (10) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (rstn) begin
      if (ignore) begin
        if (ovalid) check_eq("abort_done", 32'(done), 0);
      end else if (ovalid) begin
        if (!seen_ov) begin
          seen_ov  = 1'b1;
          first_ov = cyc;
        end
        if (sb.size() == 0) begin
          check_eq("extra_ovalid", 32'(ovalid), 0);
        end else begin
          mon_e = sb.pop_front();
          check_eq("dout", dout, mon_e.v);
          check_eq("done", 32'(done), 32'(mon_e.last));
        end
      end else if (done) begin
        check_eq("done_wo_ovalid", 32'(done), 0);
      end
    end
  end

  initial begin
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("rst_dout", dout, 0);
    check_eq("rst_ovalid", 32'(ovalid), 0);
    check_eq("rst_done", 32'(done), 0);
    rstn = 1'b1;
    @(negedge clk);

    load_w(25'h0000000);
    run_frame(1, LAYER1, 0, W0 * W0, -1);
    drain();

    load_w(25'h1FFFFFF);
    run_frame(2, LAYER1, 0, W0 * W0, 116);
    drain();
    check_eq("latency", 32'(first_ov - acc_edge), 2);

    load_w(25'h1000000);
    run_frame(3, LAYER1, 0, W0 * W0, -1);
    drain();

    load_w(25'h1FFFFFF);
    run_frame(4, LAYER2, 0, W1 * W1, -1);
    drain();

    load_w(25'h0000000);
    run_frame(1, LAYER1, 2, W0 * W0, -1);
    drain();

    ignore = 1'b1;
    run_frame(1, LAYER1, 0, 300, -1);
    rstn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      check_eq("abort_rst_dout", dout, 0);
      check_eq("abort_rst_ovalid", 32'(ovalid), 0);
      check_eq("abort_rst_done", 32'(done), 0);
    end
    rstn   = 1'b1;
    ignore = 1'b0;
    @(negedge clk);
    load_w(25'h0000000);
    run_frame(1, LAYER1, 0, W0 * W0, -1);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/bnn_conv_core.md
# bnn_conv_core

Binary-weight 5x5 convolution engine for the BNN MNIST datapath. It takes a raster pixel stream and builds 5-pixel vertical columns through line buffers. It convolves each 5x5 window with a serially loaded ±1 kernel and emits one signed 32-bit sum per valid window position. The `state` input selects the layer: 0 = 28x28 input giving 24x24 = 576 outputs, 1 = 12x12 input giving 8x8 = 64 outputs.

## Interface
- `K`, 5, kernel edge.
- `DW`, 8, pixel width (unsigned).
- `OW`, 32, result width (signed).
- `W0`, 28, image edge for state 0.
- `W1`, 12, image edge for state 1.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rstn`  in  1  reset, synchronous, active-low.
- `start`  in  1  arm a frame; level-sampled in IDLE.
- `state`  in  1  layer select; sampled when leaving IDLE.
- `din_valid`  in  1  `din` valid this cycle.
- `din`  in  DW  pixel, raster order, row-major.
- `weight_en`  in  1  shift-enable for the kernel register.
- `weight`  in  1  kernel bit (1 = +1, 0 = −1).
- `dout`  out  OW  signed convolution sum.
- `ovalid`  out  1  `dout` valid.
- `done`  out  1  last output of frame; asserted together with `ovalid`.

## Operation
- Kernel register `w[24:0]` shifts while `weight_en`=1: `w <= {w[23:0], weight}`.
  - After 25 shifts, the first bit shifted in is position (0,0) and the last is (4,4).
  - Kernel position (i,j) uses `w[24-(5i+j)]`.
  - Loading is allowed at any time; each sum uses the register value on the cycle it is computed.
- Window path (sub-module `line_window`):
  - Four line buffers of W×DW bits, where W = `W0` or `W1`.
  - Each accepted pixel produces one column `taps[39:0]`: `taps[39:32]` = pixel 4 rows above, …, `taps[7:0]` = current pixel.
  - A `taps_valid` flag accompanies each column.
- Conv path keeps a 5-column shift register of taps. Each window is correlated, not flipped: out(r,c) = Σ_{i,j} s(i,j)·pix(r+i,c+j), where s = +1 if the weight bit is 1, −1 if it is 0.
  - Pixels are zero-extended.
  - The sum range is ±6375; it is sign-extended to OW.
- Frame FSM:
  - IDLE → RUN when `start`=1 (latches `state`, clears row/col counters).
  - RUN → IDLE on the cycle `done` is output.
  - If `start` is still 1 in IDLE, the next frame arms immediately.
- In RUN, counters advance only on `taps_valid`.
  - An output is produced for every pixel with row ≥ 4 and col ≥ 4.
  - Total outputs: 576 (state 0) or 64 (state 1), in raster order.
- `din_valid`=0 stalls both paths; no state advances and no output is produced. Results are independent of gap pattern.
- Pixels arriving in IDLE are ignored.
- `state` changes during RUN are ignored.

## Timing
- Reset (`rstn`=0 at an edge) values:
  - `dout`=0, `ovalid`=0, `done`=0; FSM = IDLE.
  - Counters and window registers = 0; line buffers = 0.
  - `w` = 0.
- Reset mid-frame aborts the frame; no `done` is issued.
- Latency: `dout`/`ovalid` for window (r,c) are asserted 2 cycles after the edge accepting pixel (r+4,c+4).
  - Cycle 1: registered taps column.
  - Cycle 2: registered sum.
- `ovalid` is high for exactly one cycle per output.
- `done` is high for one cycle, coincident with the final `ovalid`.
- Full-rate input (`din_valid` always 1) gives up to 1 output per cycle. Row wrap produces 4 no-output cycles per row.
- The `weight` bit shifted in at edge t affects sums computed from edge t+1 onward.

## Structure
- Package `bnn_conv_pkg` holds:
  - constants K, DW, OW, W0, W1;
  - state encoding (`LAYER1`=0, `LAYER2`=1);
  - FSM state enum {IDLE, RUN}.
- Sub-module `line_window` contains the line buffers, the column counter, and `taps`/`taps_valid` generation.
- The top level contains the kernel register, the 5x5 tap matrix, the adder tree, the counters, and the FSM.

## Test plan
- State 0; `weight`=0 for 25 shifts; 784 pixels all = 1 at full rate.
  - Expect 576 outputs, each −25.
  - `done` with the 576th output, then `ovalid` stays low.
- State 0; all weights 1; all pixels 255.
  - Expect every `dout` = 6375.
  - First `ovalid` 2 cycles after pixel index 116 (row 4, col 4) is accepted.
- State 0; only (0,0) weight = 1; single pixel 100 at (10,10), others 0.
  - Expect out(10,10) = +100.
  - Expect out(r,c) = −100 for the other 24 windows covering (10,10).
  - All other outputs = 0.
- State 1; 12x12 image with pix = column index; all weights 1.
  - Expect 64 outputs, out(r,c) = 5·(5c+10) = 25c+50.
  - `done` with the 64th output.
- Repeat scenario 1 with `din_valid` toggling 1,0,0 → identical 576 values and order.
- Assert `rstn`=0 after 300 pixels, then restart with `start`.
  - Expect outputs zero during reset and no `done` from the aborted frame.
  - Expect the new frame to produce the full, correct output set.
